// File: rtl/jt6295_phrase_fetch_if.sv
// Request, control-ROM and result signals of the phrase fetcher.
// The slave modport is the fetcher; the master modport is the requester/ROM side.
interface jt6295_phrase_fetch_if;
    logic        req;
    logic [6:0]  req_phrase;
    logic [1:0]  req_ch;
    logic [17:0] ctrl_addr;
    logic [7:0]  ctrl_dout;
    logic        ctrl_ok;
    logic [17:0] start_addr;
    logic [17:0] stop_addr;
    logic        done;
    logic [1:0]  done_ch;
    logic        err;
    logic        busy;
    logic        ovf;

    modport slave (
        input  req, req_phrase, req_ch, ctrl_dout, ctrl_ok,
        output ctrl_addr, start_addr, stop_addr, done, done_ch, err, busy, ovf
    );
    modport master (
        output req, req_phrase, req_ch, ctrl_dout, ctrl_ok,
        input  ctrl_addr, start_addr, stop_addr, done, done_ch, err, busy, ovf
    );
endinterface

// File: rtl/jt6295_phrase_fetch.sv
// Reads the 6-byte start/stop entry of a phrase from the control ROM
// behind a one-deep request buffer and reports it with a one-cycle done strobe.
module jt6295_phrase_fetch (
    input  logic                        clk,
    input  logic                        rst,
    jt6295_phrase_fetch_if.slave        bus
);
    typedef enum logic [2:0] {IDLE, ADDR, SKIP, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic        pend_vld_q;
    logic [6:0]  pend_phrase_q;
    logic [1:0]  pend_ch_q;
    logic [6:0]  phrase_q;
    logic [1:0]  ch_q;
    logic [2:0]  cnt_q;
    logic [17:0] ctrl_addr_q;
    logic [17:0] st_acc_q;
    logic [17:8] sp_acc_q;
    logic [17:0] start_q, stop_q;
    logic [1:0]  done_ch_q;
    logic        err_q, ovf_q;
    logic        consume, byte_ok;
    logic [2:0]  cnt_nxt;
    logic [17:0] stop_w;

    assign consume = (state_q == IDLE) && pend_vld_q;
    assign byte_ok = (state_q == WAIT) && bus.ctrl_ok;
    assign cnt_nxt = cnt_q + 3'd1;
    assign stop_w  = {sp_acc_q, bus.ctrl_dout};

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (pend_vld_q) state_d = (pend_phrase_q == 7'd0) ? DONE : ADDR;
            ADDR: state_d = SKIP;
            SKIP: state_d = WAIT;
            WAIT: if (bus.ctrl_ok) state_d = (cnt_q == 3'd5) ? DONE : ADDR;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld_q    <= 1'b0;
            pend_phrase_q <= 7'd0;
            pend_ch_q     <= 2'd0;
            phrase_q      <= 7'd0;
            ch_q          <= 2'd0;
            cnt_q         <= 3'd0;
            ctrl_addr_q   <= 18'd0;
            st_acc_q      <= 18'd0;
            sp_acc_q      <= 10'd0;
            start_q       <= 18'd0;
            stop_q        <= 18'd0;
            done_ch_q     <= 2'd0;
            err_q         <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            // A slot freed this cycle can take the incoming request directly
            if (bus.req && (!pend_vld_q || consume)) begin
                pend_vld_q    <= 1'b1;
                pend_phrase_q <= bus.req_phrase;
                pend_ch_q     <= bus.req_ch;
            end else if (consume) begin
                pend_vld_q    <= 1'b0;
            end
            ovf_q <= bus.req && pend_vld_q && !consume;

            if (consume) begin
                phrase_q <= pend_phrase_q;
                ch_q     <= pend_ch_q;
                cnt_q    <= 3'd0;
                if (pend_phrase_q == 7'd0) begin
                    start_q   <= 18'd0;
                    stop_q    <= 18'd0;
                    err_q     <= 1'b1;
                    done_ch_q <= pend_ch_q;
                end else begin
                    ctrl_addr_q <= {8'd0, pend_phrase_q, 3'd0};
                end
            end

            if (byte_ok) begin
                case (cnt_q)
                    3'd0: st_acc_q[17:16] <= bus.ctrl_dout[1:0];
                    3'd1: st_acc_q[15:8]  <= bus.ctrl_dout;
                    3'd2: st_acc_q[7:0]   <= bus.ctrl_dout;
                    3'd3: sp_acc_q[17:16] <= bus.ctrl_dout[1:0];
                    3'd4: sp_acc_q[15:8]  <= bus.ctrl_dout;
                    default: ;
                endcase
                if (cnt_q == 3'd5) begin
                    start_q   <= st_acc_q;
                    stop_q    <= stop_w;
                    err_q     <= (stop_w < st_acc_q);
                    done_ch_q <= ch_q;
                end else begin
                    // Entry base is 8-aligned, so the byte index fills the low bits
                    cnt_q       <= cnt_nxt;
                    ctrl_addr_q <= {8'd0, phrase_q, cnt_nxt};
                end
            end
        end
    end

    always_comb begin
        bus.done       = (state_q == DONE);
        bus.busy       = (state_q != IDLE) || pend_vld_q;
        bus.ctrl_addr  = ctrl_addr_q;
        bus.start_addr = start_q;
        bus.stop_addr  = stop_q;
        bus.done_ch    = done_ch_q;
        bus.err        = err_q;
        bus.ovf        = ovf_q;
    end
endmodule

// File: doc/jt6295_phrase_fetch.md
JT6295_PHRASE_FETCH -- requirements
Module: jt6295_phrase_fetch

Interface
REQ-001 SHALL have port rst  input  1  synchronous active-high reset.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port req  input  1  one-cycle phrase start request.
REQ-004 SHALL have port req_phrase  input  7  phrase number, 1..127 valid.
REQ-005 SHALL have port req_ch  input  2  target channel.
REQ-006 SHALL have port ctrl_addr  output  18  control ROM byte address.
REQ-007 SHALL have port ctrl_dout  input  8  control ROM byte for ctrl_addr.
REQ-008 SHALL have port ctrl_ok  input  1  ctrl_dout valid for current ctrl_addr.
REQ-009 SHALL have port start_addr  output  18  fetched phrase start address.
REQ-010 SHALL have port stop_addr  output  18  fetched phrase stop address.
REQ-011 SHALL have port done  output  1  one-cycle strobe: start/stop/done_ch valid.
REQ-012 SHALL have port done_ch  output  2  channel of completed fetch.
REQ-013 SHALL have port err  output  1  qualifies done: phrase 0 or stop_addr < start_addr.
REQ-014 SHALL have port busy  output  1  fetch in progress or request pending.
REQ-015 SHALL have port ovf  output  1  one-cycle strobe: request dropped.

Function
REQ-016 SHALL hold a single-entry pending register (phrase, ch, valid) loaded on req when empty.
REQ-017 SHALL, on req while pending full, drop the request and pulse ovf the next cycle; pending content unchanged.
REQ-018 SHALL, on req in the same cycle pending is consumed, load the new request (no ovf).
REQ-019 SHALL use FSM states IDLE, ADDR, SKIP, WAIT, DONE.
REQ-020 IDLE: pending valid -> consume it, byte counter cnt=0, go ADDR; else stay.
REQ-021 SHALL treat phrase 0 as error: IDLE -> DONE directly, start_addr=stop_addr=0, err=1, no ROM access.
REQ-022 ADDR: drive ctrl_addr = {8'd0, phrase, 3'd0} + cnt (cnt 0..5, 3 bits), go SKIP.
REQ-023 SKIP: ignore ctrl_ok for exactly one cycle (stale status from previous address), go WAIT.
REQ-024 WAIT: on ctrl_ok=1 capture ctrl_dout into byte cnt; cnt<5 -> cnt+1, ADDR; cnt=5 -> DONE; ctrl_ok=0 -> stay, no timeout.
REQ-025 Byte map: b0[1:0]=start[17:16], b1=start[15:8], b2=start[7:0], b3[1:0]=stop[17:16], b4=stop[15:8], b5=stop[7:0]; b0[7:2], b3[7:2] ignored.
REQ-026 DONE: assert done=1 for one cycle with start_addr, stop_addr, done_ch, err; go IDLE.
REQ-027 err SHALL be 1 when stop_addr < start_addr (unsigned 18-bit); equal is valid.
REQ-028 start_addr, stop_addr, done_ch SHALL hold their values until the next DONE.
REQ-029 ctrl_addr SHALL hold stable in SKIP and WAIT and hold last value in IDLE/DONE.
REQ-030 busy SHALL be 1 whenever state != IDLE or pending valid.
REQ-031 Minimum fetch latency, req to done, with ctrl_ok high on first WAIT cycle: 1 (pending) + 6x3 + 1 = 20 cycles.

Reset
REQ-032 rst SHALL force state IDLE, cnt=0, pending valid=0, ctrl_addr=0, start_addr=0, stop_addr=0, done_ch=0, done=0, err=0, ovf=0, busy=0.
REQ-033 rst mid-fetch SHALL abandon the fetch with no done pulse; the pending request is lost.
REQ-034 req asserted together with rst SHALL be ignored.

Verification
REQ-035 req phrase=1 ch=2, ROM[8..13]=01 23 45 02 00 10, ctrl_ok 2 cycles after each address -> done, start=0x12345, stop=0x20010, done_ch=2, err=0.
REQ-036 req phrase=0 ch=1 -> done within 3 cycles, err=1, start=stop=0, ctrl_addr unchanged.
REQ-037 ROM stop bytes 00 00 10 vs start 00 00 20 -> done, err=1, addresses still reported.
REQ-038 Three reqs on consecutive cycles while idle -> first fetched, second pending then fetched, third dropped with ovf pulse; exactly 2 done pulses.
REQ-039 ctrl_ok held high throughout -> stale ok in SKIP ignored; each byte captured from correct address 8p..8p+5.
REQ-040 rst asserted in WAIT at cnt=3 with pending full -> no done; busy=0 next cycle; all outputs at reset values.
